mult_share_arbiter: RTL

Sequencing and arbitration controller that shares one combinational `binary_multiplier_behavioral` instance between two requesters. Each requester hands over an operand pair with a valid/ready handshake. The block grants the multiplier round-robin, drives the multiplier operands from registers, captures the product, and returns it on a per-requester response handshake. It sits between the requesting datapaths and the multiplier instance, which is instantiated alongside it and wired to the `mul_*` ports.

---
 rtl/mult_share_arbiter_if.sv | 57 +++++
 rtl/mult_share_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mult_share_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mult_share_arbiter_if
// Purpose : Bundles the two requester handshakes, the shared-multiplier
//           operand/product wires and the status outputs of
//           mult_share_arbiter.
// Ports   : slave  - seen from the arbiter (requests and mul_product in,
//                    readies, responses, operands and status out)
//           master - seen from the requesters / multiplier side
// Rev     : 1.0  initial release
// ============================================================================
interface mult_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic                 req0_valid;
  logic [WIDTH-1:0]     req0_a;
  logic [WIDTH-1:0]     req0_b;
  logic                 req0_ready;
  logic                 rsp0_valid;
  logic [2*WIDTH-1:0]   rsp0_product;
  logic                 rsp0_ready;

  logic                 req1_valid;
  logic [WIDTH-1:0]     req1_a;
  logic [WIDTH-1:0]     req1_b;
  logic                 req1_ready;
  logic                 rsp1_valid;
  logic [2*WIDTH-1:0]   rsp1_product;
  logic                 rsp1_ready;

  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_product;

  logic                 busy;
  logic                 owner;

  modport slave (
    input  req0_valid, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_a, req1_b, rsp1_ready,
    input  mul_product,
    output req0_ready, rsp0_valid, rsp0_product,
    output req1_ready, rsp1_valid, rsp1_product,
    output mul_a, mul_b, busy, owner
  );

  modport master (
    output req0_valid, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_a, req1_b, rsp1_ready,
    output mul_product,
    input  req0_ready, rsp0_valid, rsp0_product,
    input  req1_ready, rsp1_valid, rsp1_product,
    input  mul_a, mul_b, busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mult_share_arbiter
// Purpose : Shares one combinational multiplier between two requesters.
//           Round-robin grant in IDLE, one settle cycle in MUL, then the
//           product is held on the owner's response handshake in RESP.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - mult_share_arbiter_if.slave (request/response handshakes,
//                  mul_a/mul_b/mul_product to the multiplier, busy, owner)
// Rev     : 1.0  initial release
// ============================================================================
module mult_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mult_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_owner;
  logic                 r_last_grant;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  // Per-requester product registers double as the result register: only the
  // owner's copy is loaded, so the other output keeps its previous value.
  logic [2*WIDTH-1:0]   r_rsp0_product;
  logic [2*WIDTH-1:0]   r_rsp1_product;
  logic                 r_rsp0_valid;
  logic                 r_rsp1_valid;

  logic                 w_winner;
  logic                 w_ready0;
  logic                 w_ready1;
  logic                 w_rsp_ready;

  // On a tie the requester that was not served last wins; otherwise the
  // single valid requester wins.
  assign w_winner = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant
                                                       : bus.req1_valid;

  // Ready is gated by the requester's own valid so that an idle bus never
  // advertises a grant; rst forces both low while the reset is applied.
  assign w_ready0 = (r_state == ST_IDLE) && !rst && bus.req0_valid && !w_winner;
  assign w_ready1 = (r_state == ST_IDLE) && !rst && bus.req1_valid &&  w_winner;

  assign w_rsp_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_owner        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_rsp0_product <= '0;
      r_rsp1_product <= '0;
      r_rsp0_valid   <= 1'b0;
      r_rsp1_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ready0 || w_ready1) begin
            r_mul_a <= w_ready1 ? bus.req1_a : bus.req0_a;
            r_mul_b <= w_ready1 ? bus.req1_b : bus.req0_b;
            r_owner <= w_ready1;
            r_state <= ST_MUL;
          end
        end
        ST_MUL: begin
          // Operands have been stable for a full cycle; the product is settled.
          if (r_owner) begin
            r_rsp1_product <= bus.mul_product;
            r_rsp1_valid   <= 1'b1;
          end else begin
            r_rsp0_product <= bus.mul_product;
            r_rsp0_valid   <= 1'b1;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          // The round-robin pointer moves only on a completed response.
          if (w_rsp_ready) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_last_grant <= r_owner;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready   = w_ready0;
  assign bus.req1_ready   = w_ready1;
  assign bus.rsp0_valid   = r_rsp0_valid;
  assign bus.rsp1_valid   = r_rsp1_valid;
  assign bus.rsp0_product = r_rsp0_product;
  assign bus.rsp1_product = r_rsp1_product;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.owner        = r_owner;

endmodule
`default_nettype wire
